fpdiv_frac_iter: RTL and testbench
==================================

Name: fpdiv_frac_iter

Overview:
Parametrised, iterative radix-2 restoring mantissa divider. It is the next-generation fraction core behind the FP divide path.
- Width is generic (FRAC_W).
- Per-request precision is selectable, and iteration count terminates early for narrower formats.
- It produces a remainder-nonzero (sticky) flag and flags illegal (unnormalised) divisors.
- It sits between the FP unpack/exponent logic and the rounding stage, with valid-ready handshakes on both sides and a flush.

Parameters:
FRAC_W, 53, significand width including hidden bit; operands are MSB-aligned in this width
P_FMT0, 11, precision used when fp_format_i=2'b00 (fp16); must be <= FRAC_W
P_FMT1, 24, precision used when fp_format_i=2'b01 (fp32); must be <= FRAC_W
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > FRAC_W+2

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
flush_i  in  1  abort any operation, return to IDLE
start_valid_i  in  1  request valid
start_ready_o  out  1  block can accept a request
fp_format_i  in  2  00: P=P_FMT0, 01: P=P_FMT1, 10/11: P=FRAC_W
opa_frac_i  in  FRAC_W  dividend significand, MSB must be 1
opb_frac_i  in  FRAC_W  divisor significand, MSB must be 1
finish_valid_o  out  1  result valid
finish_ready_i  in  1  consumer accepts result
quo_o  out  FRAC_W+2  quotient, MSB-aligned
rem_nz_o  out  1  remainder nonzero (sticky)
div_err_o  out  1  divisor MSB was 0

Behaviour:
Interface:
- One clock; reset is synchronous and active-high.
- Clock port is clk; reset port is rst.

Reset:
- State becomes IDLE.
- start_ready_o=0 while rst=1, and 1 in the cycle after rst deasserts.
- finish_valid_o=0, quo_o=0, rem_nz_o=0, div_err_o=0.

Arithmetic:
- A = opa_frac_i[FRAC_W-1 -: P], B = opb_frac_i[FRAC_W-1 -: P]; lower operand bits are ignored.
- Q = floor(A*2^(P+1)/B), which is P+2 bits.
- quo_o[FRAC_W+1 -: P+2] = Q; the remaining low bits of quo_o = 0.
- rem_nz_o = (A*2^(P+1) mod B) != 0.
- quo_o[FRAC_W+1] is 1 iff A >= B.

State machine: IDLE, ITER, DONE.
- IDLE:
  - start_ready_o=1.
  - On start_valid_i & start_ready_o & !flush_i: latch A, B and P.
  - If opb MSB=1: set counter=P+2, go to ITER.
  - If opb MSB=0: quo_o=all ones, rem_nz_o=0, div_err_o=1, go to DONE. finish_valid_o is high the cycle after the handshake.
- ITER:
  - One quotient bit per cycle, MSB first; partial remainder is P+2 bits.
  - The counter decrements each cycle. When it reaches 0, go to DONE.
  - Latency: finish_valid_o rises exactly P+2 cycles after the start-handshake edge (fp16 13, fp32 26, fp64 55).
- DONE:
  - finish_valid_o=1.
  - quo_o, rem_nz_o and div_err_o are held stable until finish_valid_o & finish_ready_i, then go to IDLE.
  - start_ready_o=0 in DONE. No same-cycle restart: the next request is accepted at the earliest one cycle after the finish handshake.

Boundary conditions:
- flush_i in any state: go to IDLE at the next edge, finish_valid_o=0, no result is delivered.
- flush_i takes priority over a simultaneous start or finish handshake.
- rst overrides flush_i.
- Inputs are ignored outside the IDLE handshake; changing them mid-ITER has no effect.
- Dividend MSB=0 is not checked; the result follows the arithmetic definition.
- Outputs are registered; no combinational path from start_valid_i to finish_valid_o.

Test Plan:
- fp16 (fmt 00), A=B=1.0 (top 11 bits 11'h400) -> quo_o[54:42]=13'h1000, low bits 0, rem_nz_o=0, div_err_o=0, finish_valid_o 13 cycles after handshake.
- fp32 (fmt 01), A=1.5 (24'hC00000), B=1.0 (24'h800000) -> quo_o[54:29]=26'h3000000, rem_nz_o=0, latency 26.
- fp64 (fmt 10), A=1.0, B=1.5 -> quo_o=55'h2AAAAAAAAAAAAA, rem_nz_o=1, latency 55.
- Divisor opb_frac_i=0 -> quo_o all ones, div_err_o=1, finish_valid_o the cycle after handshake.
- fp64 start, flush_i pulsed 10 cycles later -> start_ready_o=1 the next cycle, finish_valid_o never asserts; a following fp16 1.0/1.0 request returns 13'h1000 correctly.
- Any result with finish_ready_i held low 5 cycles -> finish_valid_o stays 1, outputs stable, start_ready_o=0; handshake then gives start_ready_o=1 the next cycle. rst asserted mid-ITER -> reset values next cycle.

Source files
------------

// File: rtl/fpdiv_frac_iter.sv
// Iterative radix-2 restoring significand divider with per-request precision.
// Produces an MSB-aligned quotient, a sticky remainder flag, and flags unnormalised divisors.
module fpdiv_frac_iter #(
  parameter int unsigned FRAC_W = 53,
  parameter int unsigned P_FMT0 = 11,
  parameter int unsigned P_FMT1 = 24,
  parameter int unsigned CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              start_valid_i,
  output logic              start_ready_o,
  input  logic [1:0]        fp_format_i,
  input  logic [FRAC_W-1:0] opa_frac_i,
  input  logic [FRAC_W-1:0] opb_frac_i,
  output logic              finish_valid_o,
  input  logic              finish_ready_i,
  output logic [FRAC_W+1:0] quo_o,
  output logic              rem_nz_o,
  output logic              div_err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  p_sel;
  logic [FRAC_W-1:0] op_mask;
  logic [FRAC_W-1:0] b_q;
  logic [FRAC_W:0]   rem_q;
  logic [FRAC_W:0]   rem_sh;
  logic [FRAC_W:0]   rem_nx;
  logic              q_bit;
  logic [FRAC_W+1:0] quo_q;
  logic [FRAC_W+1:0] qbit_mask;
  logic              first_q;
  logic              ready_q;
  logic              rem_nz_q;
  logic              div_err_q;

  // Narrow formats keep operands MSB-aligned and zero the ignored low bits, so the
  // datapath stays FRAC_W wide and only the iteration count changes.
  always_comb begin
    p_sel = CNT_W'(FRAC_W);
    case (fp_format_i)
      2'b00:   p_sel = CNT_W'(P_FMT0);
      2'b01:   p_sel = CNT_W'(P_FMT1);
      default: p_sel = CNT_W'(FRAC_W);
    endcase
    op_mask = {FRAC_W{1'b1}} << (CNT_W'(FRAC_W) - p_sel);
  end

  // First step compares the unshifted dividend to produce the integer quotient bit.
  always_comb begin
    rem_sh = first_q ? rem_q : (rem_q << 1);
    q_bit  = rem_sh >= {1'b0, b_q};
    rem_nx = q_bit ? (rem_sh - {1'b0, b_q}) : rem_sh;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ready_q   <= 1'b0;
      cnt       <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      qbit_mask <= '0;
      first_q   <= 1'b0;
      rem_nz_q  <= 1'b0;
      div_err_q <= 1'b0;
    end else if (flush_i) begin
      state   <= S_IDLE;
      ready_q <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          ready_q <= 1'b1;
          if (start_valid_i && ready_q) begin
            ready_q  <= 1'b0;
            rem_nz_q <= 1'b0;
            if (opb_frac_i[FRAC_W-1]) begin
              b_q       <= opb_frac_i & op_mask;
              rem_q     <= {1'b0, opa_frac_i & op_mask};
              cnt       <= p_sel + CNT_W'(2);
              quo_q     <= '0;
              qbit_mask <= {1'b1, {(FRAC_W+1){1'b0}}};
              first_q   <= 1'b1;
              div_err_q <= 1'b0;
              state     <= S_ITER;
            end else begin
              quo_q     <= '1;
              div_err_q <= 1'b1;
              state     <= S_DONE;
            end
          end
        end
        S_ITER: begin
          first_q   <= 1'b0;
          rem_q     <= rem_nx;
          quo_q     <= quo_q | (q_bit ? qbit_mask : '0);
          qbit_mask <= qbit_mask >> 1;
          cnt       <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            rem_nz_q <= |rem_nx;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          if (finish_ready_i) begin
            ready_q <= 1'b1;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign start_ready_o  = ready_q;
  assign finish_valid_o = (state == S_DONE);
  assign quo_o          = quo_q;
  assign rem_nz_o       = rem_nz_q;
  assign div_err_o      = div_err_q;

endmodule

// File: tb/tb_fpdiv_frac_iter.sv
// Directed bench for fpdiv_frac_iter: arithmetic reference model plus literal pins,
// latency, back-pressure, flush and reset checks.
module tb_fpdiv_frac_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        start_valid_i;
  logic        start_ready_o;
  logic [1:0]  fp_format_i;
  logic [52:0] opa_frac_i;
  logic [52:0] opb_frac_i;
  logic        finish_valid_o;
  logic        finish_ready_i;
  logic [54:0] quo_o;
  logic        rem_nz_o;
  logic        div_err_o;

  int total = 0;
  int bad   = 0;

  logic [54:0] exp_quo;
  logic        exp_nz;
  logic        exp_err;
  logic        exp_on = 1'b0;
  int          exp_lat;

  fpdiv_frac_iter #(.FRAC_W(53), .P_FMT0(11), .P_FMT1(24), .CNT_W(6)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush_i        (flush_i),
    .start_valid_i  (start_valid_i),
    .start_ready_o  (start_ready_o),
    .fp_format_i    (fp_format_i),
    .opa_frac_i     (opa_frac_i),
    .opb_frac_i     (opb_frac_i),
    .finish_valid_o (finish_valid_o),
    .finish_ready_i (finish_ready_i),
    .quo_o          (quo_o),
    .rem_nz_o       (rem_nz_o),
    .div_err_o      (div_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: Q = floor(A*2^(P+1)/B) on the top P bits, placed MSB-aligned.
  task automatic set_expect(input logic [1:0] fmt, input logic [52:0] a, input logic [52:0] b);
    int unsigned p;
    logic [127:0] aa, bb, num;
    p = (fmt == 2'b00) ? 11 : (fmt == 2'b01) ? 24 : 53;
    if (!b[52]) begin
      exp_quo = '1;
      exp_nz  = 1'b0;
      exp_err = 1'b1;
      exp_lat = 0;
    end else begin
      aa      = 128'(a) >> (53 - p);
      bb      = 128'(b) >> (53 - p);
      num     = aa << (p + 1);
      exp_quo = 55'((num / bb) << (53 - p));
      exp_nz  = (num % bb) != 0;
      exp_err = 1'b0;
      exp_lat = int'(p) + 2;
    end
    exp_on = 1'b1;
  endtask

  always @(negedge clk) begin
    if (!rst && finish_valid_o) begin
      chk("valid_expected", 64'(exp_on), 64'd1);
      chk("ready_in_done", 64'(start_ready_o), 64'd0);
      if (exp_on) begin
        chk("quo", 64'(quo_o), 64'(exp_quo));
        chk("rem_nz", 64'(rem_nz_o), 64'(exp_nz));
        chk("div_err", 64'(div_err_o), 64'(exp_err));
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!start_ready_o && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("start_ready_wait", 64'(start_ready_o), 64'd1);
  endtask

  task automatic issue(input logic [1:0] fmt, input logic [52:0] a, input logic [52:0] b);
    wait_ready();
    start_valid_i = 1'b1;
    fp_format_i   = fmt;
    opa_frac_i    = a;
    opb_frac_i    = b;
    set_expect(fmt, a, b);
    @(posedge clk); #1;
    start_valid_i = 1'b0;
    fp_format_i   = 2'($urandom);
    opa_frac_i    = 53'({$urandom, $urandom});
    opb_frac_i    = 53'({$urandom, $urandom});
  endtask

  task automatic run_req(input logic [1:0] fmt, input logic [52:0] a, input logic [52:0] b,
                         input int hold, input bit use_lit, input logic [54:0] lit_quo,
                         input logic lit_nz, input logic lit_err);
    int n = 0;
    issue(fmt, a, b);
    while (!finish_valid_o && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 64'(n), 64'(exp_lat));
    if (use_lit) begin
      chk("lit_quo", 64'(quo_o), 64'(lit_quo));
      chk("lit_nz", 64'(rem_nz_o), 64'(lit_nz));
      chk("lit_err", 64'(div_err_o), 64'(lit_err));
    end
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", 64'(finish_valid_o), 64'd1);
      chk("hold_ready", 64'(start_ready_o), 64'd0);
      opa_frac_i = 53'({$urandom, $urandom});
      opb_frac_i = 53'({$urandom, $urandom});
      @(posedge clk); #1;
    end
    finish_ready_i = 1'b1;
    @(posedge clk); #1;
    finish_ready_i = 1'b0;
    exp_on = 1'b0;
    chk("post_hs_valid", 64'(finish_valid_o), 64'd0);
    chk("post_hs_ready", 64'(start_ready_o), 64'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [52:0] ra, rb;
    rst = 1'b1; flush_i = 1'b0; start_valid_i = 1'b0; finish_ready_i = 1'b0;
    fp_format_i = 2'b00; opa_frac_i = '0; opb_frac_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(start_ready_o), 64'd0);
    chk("rst_valid", 64'(finish_valid_o), 64'd0);
    chk("rst_quo", 64'(quo_o), 64'd0);
    chk("rst_nz", 64'(rem_nz_o), 64'd0);
    chk("rst_err", 64'(div_err_o), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_release_ready", 64'(start_ready_o), 64'd1);

    // fp16 1.0/1.0 with junk in the ignored low bits
    run_req(2'b00, 53'h10000000000000 | 53'h3FF, 53'h10000000000000 | 53'h155, 0,
            1'b1, 55'h40000000000000, 1'b0, 1'b0);
    // fp32 1.5/1.0 with 5 cycles of back-pressure
    run_req(2'b01, 53'h18000000000000, 53'h10000000000000, 5,
            1'b1, 55'h60000000000000, 1'b0, 1'b0);
    // fp64 1.0/1.5
    run_req(2'b10, 53'h10000000000000, 53'h18000000000000, 0,
            1'b1, 55'h2AAAAAAAAAAAAA, 1'b1, 1'b0);
    // divisor zero
    run_req(2'b01, 53'h15555555555555, 53'h0, 2,
            1'b1, 55'h7FFFFFFFFFFFFF, 1'b0, 1'b1);
    // fp16 max dividend / 1.0, fp32 1.0 / max divisor, unnormalised dividend in fp64
    run_req(2'b00, 53'h1FFFFFFFFFFFFF, 53'h10000000000000, 1, 1'b1, 55'h7FF00000000000, 1'b0, 1'b0);
    run_req(2'b01, 53'h10000000000000, 53'h1FFFFFFFFFFFFF, 0, 1'b0, '0, 1'b0, 1'b0);
    run_req(2'b11, 53'h0ABCDEF0123456, 53'h1F0F0F0F0F0F0F, 0, 1'b0, '0, 1'b0, 1'b0);

    // flush mid-ITER: no result delivered, block usable again
    issue(2'b10, 53'h13333333333333, 53'h1C000000000001);
    repeat (9) begin @(posedge clk); #1; end
    flush_i = 1'b1;
    exp_on  = 1'b0;
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk("flush_ready", 64'(start_ready_o), 64'd1);
    repeat (60) begin @(posedge clk); #1; end
    chk("flush_no_valid", 64'(finish_valid_o), 64'd0);
    run_req(2'b00, 53'h10000000000000, 53'h10000000000000, 0,
            1'b1, 55'h40000000000000, 1'b0, 1'b0);

    // flush wins over a simultaneous start (a div-err start would finish next cycle)
    start_valid_i = 1'b1; flush_i = 1'b1; opb_frac_i = '0;
    @(posedge clk); #1;
    start_valid_i = 1'b0; flush_i = 1'b0;
    chk("flush_start_valid", 64'(finish_valid_o), 64'd0);
    chk("flush_start_ready", 64'(start_ready_o), 64'd1);
    repeat (3) begin @(posedge clk); #1; end
    chk("flush_start_idle", 64'(finish_valid_o), 64'd0);

    // reset mid-ITER
    issue(2'b01, 53'h1FFFFFFFFFFFFF, 53'h10000000000001);
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    exp_on = 1'b0;
    @(posedge clk); #1;
    chk("midrst_quo", 64'(quo_o), 64'd0);
    chk("midrst_valid", 64'(finish_valid_o), 64'd0);
    chk("midrst_ready", 64'(start_ready_o), 64'd0);
    chk("midrst_nz", 64'(rem_nz_o), 64'd0);
    chk("midrst_err", 64'(div_err_o), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_release", 64'(start_ready_o), 64'd1);

    for (int k = 0; k < 6; k++) begin
      ra = 53'({$urandom, $urandom}) | (53'd1 << 52);
      rb = 53'({$urandom, $urandom}) | (53'd1 << 52);
      run_req(2'(k % 3), ra, rb, k % 2, 1'b0, '0, 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
